// File: rtl/serial_word_feeder.sv
// Parallel-to-serial word source: loads a word on start and presents it one bit
// per DIV enabled cycles on ser_out, strobing sh_en once per bit for a downstream shifter.
module serial_word_feeder #(
   parameter int WIDTH     = 4,
   parameter int DIV       = 4,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         clk_en,
   input  logic                         start,
   input  logic [WIDTH-1:0]             data_in,
   output logic                         busy,
   output logic                         ser_out,
   output logic                         sh_en,
   output logic                         done,
   output logic [$clog2(WIDTH+1)-1:0]   bit_cnt
);

   localparam int BW = $clog2(WIDTH + 1);
   localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [WIDTH-1:0] shreg;
   logic [DW-1:0]    div_cnt;
   logic             accept;

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      // NOTE: every output gets a default first so no path through the case infers a latch.
      state_next = state;
      accept     = 1'b0;
      busy       = 1'b0;
      ser_out    = 1'b0;
      sh_en      = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE: begin
            if (start && clk_en) begin
               accept     = 1'b1;
               state_next = SHIFT;
            end
         end
         SHIFT: begin
            busy    = 1'b1;
            ser_out = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
            sh_en   = clk_en && (div_cnt == DIV_LAST);
            if (sh_en && (bit_cnt == BIT_LAST)) state_next = DONE;
         end
         DONE: begin
            busy = 1'b1;
            done = clk_en;
            if (clk_en) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Datapath only moves on accept, a strobe, or an enabled SHIFT cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         shreg   <= '0;
         div_cnt <= '0;
         bit_cnt <= '0;
      end else if (accept) begin
         shreg   <= data_in;
         div_cnt <= '0;
         bit_cnt <= '0;
      end else if (sh_en) begin
         shreg   <= MSB_FIRST ? (shreg << 1) : (shreg >> 1);
         div_cnt <= '0;
         bit_cnt <= bit_cnt + BW'(1);
      end else if (clk_en && (state == SHIFT)) begin
         div_cnt <= div_cnt + DW'(1);
      end
   end

endmodule

// File: tb/tb_serial_word_feeder.sv
// Directed bench for serial_word_feeder: three instances cover MSB-first, LSB-first and DIV=1.
module tb_serial_word_feeder;

   logic       clk = 1'b0;
   logic       reset;
   logic       clk_en;
   logic [2:0] start_v;
   logic [3:0] data_in;

   logic [2:0] busy_v, ser_v, sh_v, done_v;
   logic [2:0] bc_v [3];

   int sel;
   int cyc;
   int vectors;
   int miscompares;

   logic       busy, ser_out, sh_en, done;
   logic [2:0] bit_cnt;

   always #5 clk = ~clk;

   serial_word_feeder #(.WIDTH(4), .DIV(4), .MSB_FIRST(1'b1)) u_msb (
      .clk(clk), .reset(reset), .clk_en(clk_en), .start(start_v[0]), .data_in(data_in),
      .busy(busy_v[0]), .ser_out(ser_v[0]), .sh_en(sh_v[0]), .done(done_v[0]), .bit_cnt(bc_v[0]));

   serial_word_feeder #(.WIDTH(4), .DIV(4), .MSB_FIRST(1'b0)) u_lsb (
      .clk(clk), .reset(reset), .clk_en(clk_en), .start(start_v[1]), .data_in(data_in),
      .busy(busy_v[1]), .ser_out(ser_v[1]), .sh_en(sh_v[1]), .done(done_v[1]), .bit_cnt(bc_v[1]));

   serial_word_feeder #(.WIDTH(4), .DIV(1), .MSB_FIRST(1'b1)) u_div1 (
      .clk(clk), .reset(reset), .clk_en(clk_en), .start(start_v[2]), .data_in(data_in),
      .busy(busy_v[2]), .ser_out(ser_v[2]), .sh_en(sh_v[2]), .done(done_v[2]), .bit_cnt(bc_v[2]));

   always_comb begin
      busy    = busy_v[sel];
      ser_out = ser_v[sel];
      sh_en   = sh_v[sel];
      done    = done_v[sel];
      bit_cnt = bc_v[sel];
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s (dut %0d, cycle %0d): got %0h, expected %0h", tag, sel, cyc, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // exp_seq[3] is the first bit on the wire; stall_at/abort_after of 0 disable those features.
   task automatic run_word(input int s, input logic [3:0] d, input int div, input logic [3:0] exp_seq,
                           input int stall_at, input int stall_len, input int abort_after);
      int k, t, rel;
      logic exp_sh;
      sel = s;
      data_in = d;
      start_v[s] = 1'b1;
      step();
      start_v = '0;
      data_in = 4'b0000;
      rel = 0;
      check("busy_accept", busy, 1);
      check("bitcnt_accept", bit_cnt, 0);
      k = 0;
      t = 0;
      while (k < 4 && t < 200) begin
         t++;
         if (t == 2) start_v[s] = 1'b1;
         exp_sh = (t % div == 0);
         check("sh_en", sh_en, exp_sh);
         check("ser_out", ser_out, exp_seq[3-k]);
         check("busy_shift", busy, 1);
         check("done_shift", done, 0);
         step();
         rel++;
         start_v = '0;
         if (exp_sh) begin
            k++;
            check("bit_cnt", bit_cnt, k);
            check("strobe_time", rel, k * div + ((stall_at != 0 && k > stall_at) ? stall_len : 0));
            if (k == abort_after) begin
               step();
               reset = 1'b1;
               step();
               reset = 1'b0;
               check("abort_busy", busy, 0);
               check("abort_ser", ser_out, 0);
               check("abort_bitcnt", bit_cnt, 0);
               repeat (20) begin
                  check("abort_quiet", {sh_en, done}, 2'b00);
                  step();
               end
               return;
            end
            if (k == stall_at) begin
               clk_en = 1'b0;
               repeat (stall_len) begin
                  check("stall_quiet", {sh_en, done}, 2'b00);
                  check("stall_ser", ser_out, exp_seq[3-k]);
                  step();
                  rel++;
               end
               clk_en = 1'b1;
            end
         end
      end
      if (t >= 200) check("strobe_timeout", t, 0);
      check("done_pulse", done, 1);
      check("done_busy", busy, 1);
      check("done_ser", ser_out, 0);
      check("done_time", rel + 1, 4 * div + stall_len + 1);
      start_v[s] = 1'b1;
      step();
      start_v = '0;
      check("idle_busy", busy, 0);
      check("idle_done", done, 0);
      step();
      check("start_in_done_ignored", busy, 0);
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      cyc = 0;
      sel = 0;
      reset = 1'b1;
      clk_en = 1'b0;
      start_v = '0;
      data_in = 4'b0000;
      step();
      step();
      for (int i = 0; i < 3; i++) begin
         sel = i;
         check("reset_outputs", {busy, ser_out, sh_en, done}, 4'b0000);
         check("reset_bitcnt", bit_cnt, 0);
      end
      clk_en = 1'b1;
      // start coinciding with reset must lose
      sel = 0;
      start_v[0] = 1'b1;
      data_in = 4'b1111;
      step();
      reset = 1'b0;
      start_v = '0;
      check("reset_beats_start", busy, 0);
      step();
      check("reset_beats_start_2", busy, 0);

      run_word(0, 4'b1011, 4, 4'b1011, 0, 0, 0);
      run_word(1, 4'b1011, 4, 4'b1101, 0, 0, 0);
      run_word(2, 4'b0110, 1, 4'b0110, 0, 0, 0);
      run_word(0, 4'b1011, 4, 4'b1011, 2, 3, 0);
      run_word(0, 4'b1001, 4, 4'b1001, 0, 0, 2);
      run_word(0, 4'b0101, 4, 4'b0101, 0, 0, 0);
      run_word(1, 4'b0011, 4, 4'b1100, 1, 2, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
